// File: rtl/atari_qspi_pkg.sv
// Shared types and constants for the QSPI cartridge ROM controller.
package atari_qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DONE
  } state_t;

  typedef enum logic {
    PORT_CPU,
    PORT_AUX
  } port_t;

  localparam int CMD_NIBBLES  = 2;
  localparam int ADDR_NIBBLES = 6;
  localparam int DATA_NIBBLES = 2;

  localparam logic [7:0] CMD_DEFAULT = 8'hEB;

  // Flash address is the ROM window base plus the request offset; the sum
  // deliberately wraps at 24 bits so a high base can alias low flash.
  function automatic logic [23:0] flash_addr(input logic [23:0] base,
                                             input logic [23:0] offs);
    return base + offs;
  endfunction

endpackage

// File: rtl/qspi_nibble_seq.sv
// Nibble-level sequencer: two clk cycles per nibble (sclk low, then high),
// a per-state nibble counter and the command/address shift register.
module qspi_nibble_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        shift_en,
  input  logic [3:0]  last_idx,
  output logic        sclk,
  output logic [3:0]  spi_out,
  output logic        nibble_done,
  output logic        seq_last
);

  logic        phase;
  logic [3:0]  nib_cnt;
  logic [31:0] shreg;

  assign nibble_done = run & phase;
  assign seq_last    = nibble_done & (nib_cnt == last_idx);
  assign sclk        = phase;
  assign spi_out     = shreg[31:28];

  // Phase toggles every cycle while a transaction runs; counter restarts per state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= 1'b0;
      nib_cnt <= 4'd0;
    end else if (!run) begin
      phase   <= 1'b0;
      nib_cnt <= 4'd0;
    end else begin
      phase <= ~phase;
      if (seq_last) begin
        nib_cnt <= 4'd0;
      end else if (nibble_done) begin
        nib_cnt <= nib_cnt + 4'd1;
      end
    end
  end

  // Command+address word, MSB nibble first; zero fill keeps spi_out quiet afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= 32'h0;
    end else if (load) begin
      shreg <= load_word;
    end else if (nibble_done && shift_en) begin
      shreg <= {shreg[27:0], 4'h0};
    end
  end

endmodule

// File: rtl/qspi_rom_arbiter.sv
// Two-port round-robin arbiter and quad-mode read FSM for the QSPI cartridge ROM.
module qspi_rom_arbiter
  import atari_qspi_pkg::*;
#(
  parameter int          ADDR_W   = 13,
  parameter logic [23:0] ROM_BASE = 24'h000000,
  parameter logic [7:0]  CMD      = CMD_DEFAULT,
  parameter int          DUMMY    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_ack,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              spi_select,
  output logic              spi_sclk,
  output logic [3:0]        spi_out,
  output logic [3:0]        spi_oe,
  input  logic [3:0]        spi_in
);

  state_t      state;
  state_t      state_nxt;
  port_t       last_grant;
  logic        grant_cpu;
  logic        grant_any;
  logic [31:0] load_word;
  logic        seq_run;
  logic        seq_shift;
  logic [3:0]  seq_last_idx;
  logic        nibble_done;
  logic        seq_last;

  // On a tie the port that did not win last time is served.
  assign grant_cpu = cpu_req & (~aux_req | (last_grant == PORT_AUX));
  assign grant_any = (state == ST_IDLE) & (cpu_req | aux_req);
  assign load_word = {CMD, flash_addr(ROM_BASE,
                                      grant_cpu ? 24'(cpu_addr) : 24'(aux_addr))};
  assign busy      = (state != ST_IDLE);

  qspi_nibble_seq u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (seq_run),
    .load        (grant_any),
    .load_word   (load_word),
    .shift_en    (seq_shift),
    .last_idx    (seq_last_idx),
    .sclk        (spi_sclk),
    .spi_out     (spi_out),
    .nibble_done (nibble_done),
    .seq_last    (seq_last)
  );

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant latch; doubles as the round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_AUX;
    end else if (grant_any) begin
      last_grant <= grant_cpu ? PORT_CPU : PORT_AUX;
    end
  end

  // Read byte assembled high nibble first at the end of each DATA nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 8'h00;
    end else if (state == ST_DATA && nibble_done) begin
      rdata <= {rdata[3:0], spi_in};
    end
  end

  // Next-state logic and per-state bus controls.
  always_comb begin
    state_nxt    = state;
    seq_run      = 1'b0;
    seq_shift    = 1'b0;
    seq_last_idx = 4'd0;
    spi_oe       = 4'h0;
    spi_select   = 1'b1;
    cpu_ack      = 1'b0;
    aux_ack      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_any) state_nxt = ST_CMD;
      end
      ST_CMD: begin
        seq_run      = 1'b1;
        seq_shift    = 1'b1;
        seq_last_idx = 4'(CMD_NIBBLES - 1);
        spi_oe       = 4'hF;
        spi_select   = 1'b0;
        if (seq_last) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        seq_run      = 1'b1;
        seq_shift    = 1'b1;
        seq_last_idx = 4'(ADDR_NIBBLES - 1);
        spi_oe       = 4'hF;
        spi_select   = 1'b0;
        if (seq_last) state_nxt = (DUMMY == 0) ? ST_DATA : ST_DUMMY;
      end
      ST_DUMMY: begin
        seq_run      = 1'b1;
        seq_last_idx = 4'(DUMMY - 1);
        spi_select   = 1'b0;
        if (seq_last) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        seq_run      = 1'b1;
        seq_last_idx = 4'(DATA_NIBBLES - 1);
        spi_select   = 1'b0;
        if (seq_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        cpu_ack   = (last_grant == PORT_CPU);
        aux_ack   = (last_grant == PORT_AUX);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: doc/qspi_rom_arbiter.md
Name: qspi_rom_arbiter

Overview:
- Chip-side controller for the external QSPI cartridge ROM on the bidirectional PMOD (select, sclk, 4-bit out, 4-bit in).
- Arbitrates byte reads between two requesters: the 6507 CPU fetch port and an auxiliary port used for bank-switch probing and debug.
- Sequences each read as a quad-mode transaction: command, address, dummy, data.
- The bus-facing pins are the same nibble bus the verilator QSPI ROM emulator models.

Parameters:
- ADDR_W, 13, requester address width (8K cartridge space).
- ROM_BASE, 24'h000000, added to the zero-extended request address to form the 24-bit flash address.
- CMD, 8'hEB, read command sent in quad mode.
- DUMMY, 4, dummy nibble cycles; legal range 0..15.

Ports:
- clk  in  1  system/pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU read request; level, held until cpu_ack.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_ack  out  1  one-cycle pulse; rdata valid.
- aux_req  in  1  auxiliary read request; level, held until aux_ack.
- aux_addr  in  ADDR_W  auxiliary byte address.
- aux_ack  out  1  one-cycle pulse; rdata valid.
- rdata  out  8  last byte read; shared by both ports.
- busy  out  1  high whenever state is not IDLE.
- spi_select  out  1  chip select, active low.
- spi_sclk  out  1  serial clock.
- spi_out  out  4  command/address nibble.
- spi_oe  out  4  output enable for spi_out; all ones or all zeros.
- spi_in  in  4  data nibble from the flash.

Behaviour:
- Reset values: spi_select=1, spi_sclk=0, spi_out=0, spi_oe=0, cpu_ack=0, aux_ack=0, rdata=8'h00, busy=0, state=IDLE, last_grant=AUX (so CPU wins the first tie).
- Reset asserted mid-transaction aborts it immediately. Select deasserts asynchronously and no ack is issued.
- States: IDLE -> CMD (2 nibbles) -> ADDR (6 nibbles) -> DUMMY (DUMMY nibbles; skipped if 0) -> DATA (2 nibbles) -> DONE (1 cycle) -> IDLE.
- Nibble timing: each nibble takes 2 clk cycles.
  - Phase 0: sclk=0, spi_out updated.
  - Phase 1: sclk=1; in DATA, spi_in is captured on the clk edge that ends phase 1.
- A 4-bit nibble counter and a 1-bit phase register sequence the transaction.
- Ordering: CMD and ADDR are sent MSB nibble first. In DATA the first nibble received is rdata[7:4], the second is rdata[3:0].
- Address: flash address = ROM_BASE + {0, addr}, modulo 2^24; wrap-around is allowed.
- spi_oe: 4'hF in CMD and ADDR, 4'h0 in DUMMY, DATA, DONE and IDLE.
- spi_select: 0 from CMD through DATA, 1 in DONE and IDLE. This gives at least 2 cycles deselected between transactions.
- Arbitration (evaluated only in IDLE):
  - Only one request high: grant it.
  - Both high: grant the port that is not last_grant (round-robin).
  - Grant latches the port id and address; later changes to req or addr have no effect.
- Acknowledge:
  - In DONE, the granted port's ack is 1 for exactly one cycle, with rdata already updated.
  - rdata holds until the next DATA capture.
  - If the granted requester dropped req mid-transaction, the ack still pulses.
- Latency: req sampled high in IDLE at cycle 0 -> ack at cycle 21+2*DUMMY (29 by default). The next grant is possible at cycle 22+2*DUMMY.
- Back-to-back requests from one port: the requester must drop req the cycle after its ack, or it is re-granted. A re-grant is a legal repeat read.

Decomposition:
- Package atari_qspi_pkg holds:
  - the state enum (IDLE, CMD, ADDR, DUMMY, DATA, DONE);
  - the port-id enum (CPU, AUX);
  - constants CMD_NIBBLES=2, ADDR_NIBBLES=6, DATA_NIBBLES=2;
  - the default CMD value 8'hEB.
- One sub-module: qspi_nibble_seq.
  - Owns the phase and nibble counter, sclk generation and the 32-bit out-shift register.
  - Signals nibble_done and seq_last to the FSM.
- The arbiter and FSM stay in the top.

Test Plan:
- Single CPU read, cpu_addr=13'h1FFC, ROM model holds 8'hA5 at 0x001FFC:
  - spi_out nibble sequence E,B,0,0,1,F,F,C, then 4 dummy nibbles;
  - cpu_ack at cycle 29, rdata=8'hA5, aux_ack never asserted.
- Simultaneous cpu_req and aux_req after reset: CPU is served first, then AUX.
  - Three more simultaneous rounds: grants alternate AUX/CPU.
  - Gap between the two acks is exactly 30 cycles.
- ROM_BASE=24'hFFF000, addr=13'h1800: flash address sent is 0x000800 (24-bit wrap).
  - DUMMY=0 build: ack at cycle 21.
- rst_n pulled low at cycle 12 of a transaction:
  - spi_select=1 and spi_oe=0 asynchronously, no ack, rdata=0;
  - after release, a new request completes normally.
- cpu_req dropped and cpu_addr changed during ADDR:
  - transaction completes at the original address and cpu_ack still pulses;
  - spi_oe=0 throughout DUMMY and DATA, sclk toggles every cycle while selected.
